// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares the single HAL memory port among
// NUM_MASTERS requesters, with per-master ack/busy handshakes and a busy-wait timeout.
module mem_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_read_req,
  input  logic [NUM_MASTERS-1:0]            m_write_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_write,
  output logic [DATA_WIDTH-1:0]             m_data_read,
  output logic [NUM_MASTERS-1:0]            m_busy,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              memory_read_req,
  output logic                              memory_write_req,
  output logic [ADDR_WIDTH-1:0]             memory_addr,
  output logic [DATA_WIDTH-1:0]             memory_data_write,
  input  logic [DATA_WIDTH-1:0]             memory_data_read,
  input  logic                              memory_busy
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Counter can overshoot the limit by one when busy rises on the limit cycle.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, WAIT_DONE, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [NUM_MASTERS-1:0] req;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          cand;
  logic                   grant_found;
  logic                   start;
  logic                   complete;
  logic                   timeout_hit;
  logic                   abort;
  logic                   is_write;
  logic [CW-1:0]          tcnt;

  assign req         = m_read_req | m_write_req;
  assign start       = (state == IDLE) && grant_found && !memory_busy;
  assign complete    = (state == WAIT_DONE) && !memory_busy;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt >= CW'(TIMEOUT_CYCLES));
  assign abort       = timeout_hit &&
                       (((state == ACCEPT) && !memory_busy) ||
                        ((state == WAIT_DONE) && memory_busy));

  // First requester found searching upward from the master after last_grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_MASTERS);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = ISSUE;
      ISSUE:     state_next = ACCEPT;
      ACCEPT: begin
        if (abort) state_next = DONE;
        else if (memory_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: if (complete || abort) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant        <= IW'(NUM_MASTERS - 1);
      grant             <= '0;
      is_write          <= 1'b0;
      tcnt              <= '0;
      m_data_read       <= '0;
      m_busy            <= '0;
      m_ack             <= '0;
      m_err             <= '0;
      memory_read_req   <= 1'b0;
      memory_write_req  <= 1'b0;
      memory_addr       <= '0;
      memory_data_write <= '0;
    end else begin
      memory_read_req  <= 1'b0;
      memory_write_req <= 1'b0;
      m_ack            <= '0;
      m_err            <= '0;

      if (start) begin
        grant             <= grant_idx;
        last_grant        <= grant_idx;
        is_write          <= m_write_req[grant_idx];
        memory_write_req  <= m_write_req[grant_idx];
        memory_read_req   <= !m_write_req[grant_idx];
        memory_addr       <= m_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        memory_data_write <= m_data_write[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        m_busy[grant_idx] <= 1'b1;
      end

      if (state == ISSUE) begin
        tcnt <= '0;
      end else if ((state == ACCEPT) || (state == WAIT_DONE)) begin
        tcnt <= tcnt + 1'b1;
      end

      if (complete || abort) begin
        m_busy[grant] <= 1'b0;
        m_ack[grant]  <= 1'b1;
        m_err[grant]  <= abort;
        if (complete && !is_write) m_data_read <= memory_data_read;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter (4 masters, 16-cycle timeout) checked
// every cycle against a transaction-timeline model plus hand-computed expectations.
module tb_mem_arbiter;

  localparam int NM = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [NM-1:0] ONE = 1;

  logic            clk;
  logic            reset;
  logic [NM-1:0]   m_read_req;
  logic [NM-1:0]   m_write_req;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_data_write;
  logic [DW-1:0]   m_data_read;
  logic [NM-1:0]   m_busy;
  logic [NM-1:0]   m_ack;
  logic [NM-1:0]   m_err;
  logic            memory_read_req;
  logic            memory_write_req;
  logic [AW-1:0]   memory_addr;
  logic [DW-1:0]   memory_data_write;
  logic [DW-1:0]   memory_data_read;
  logic            memory_busy;

  logic            dn_busy;
  logic            force_busy;
  logic            dn_never;
  int              dn_len;
  logic [DW-1:0]   dn_rd;
  logic [DW-1:0]   mem [logic [AW-1:0]];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  int              pulse_count = 0;
  int              ack_count = 0;
  int              pulse_cyc[$];
  int              pulse_master[$];
  bit              pulse_write[$];
  logic [AW-1:0]   pulse_addr[$];
  logic [DW-1:0]   pulse_data[$];
  int              last_ack_cyc;
  bit              last_ack_err;
  logic [DW-1:0]   last_ack_data;

  assign memory_busy = dn_busy | force_busy;

  mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_addr(m_addr), .m_data_write(m_data_write),
    .m_data_read(m_data_read), .m_busy(m_busy), .m_ack(m_ack), .m_err(m_err),
    .memory_read_req(memory_read_req), .memory_write_req(memory_write_req),
    .memory_addr(memory_addr), .memory_data_write(memory_data_write),
    .memory_data_read(memory_data_read), .memory_busy(memory_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit bit_of(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  function automatic int rr_pick(input int last, input logic [NM-1:0] r);
    for (int i = 1; i <= NM; i++) begin
      if (bit_of(r, (last + i) % NM)) return (last + i) % NM;
    end
    return -1;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Downstream memory: busy for dn_len cycles starting the cycle after a request pulse.
  initial begin
    dn_busy = 1'b0;
    memory_data_read = '0;
    dn_rd = '0;
    forever begin
      @(negedge clk);
      if (!reset && !dn_never && (memory_read_req || memory_write_req)) begin
        if (memory_write_req) begin
          mem[memory_addr] = memory_data_write;
          dn_rd = '0;
        end else begin
          dn_rd = mem.exists(memory_addr) ? mem[memory_addr] : ({6'h0, memory_addr} ^ 32'h5A5A_0000);
        end
        @(posedge clk);
        #1 dn_busy = 1'b1;
        memory_data_read = '0;
        repeat (dn_len) @(posedge clk);
        #1 dn_busy = 1'b0;
        memory_data_read = dn_rd;
      end
    end
  end

  // Transaction log used by the directed checks.
  always @(negedge clk) begin : monitor
    int who;
    if (!reset) begin
      if (memory_read_req || memory_write_req) begin
        who = -1;
        for (int i = 0; i < NM; i++) if (bit_of(m_busy, i)) who = i;
        pulse_cyc.push_back(cyc);
        pulse_master.push_back(who);
        pulse_write.push_back(memory_write_req);
        pulse_addr.push_back(memory_addr);
        pulse_data.push_back(memory_data_write);
        pulse_count++;
      end
      if (|m_ack) begin
        ack_count++;
        last_ack_cyc  = cyc;
        last_ack_err  = |m_err;
        last_ack_data = m_data_read;
      end
    end
  end

  // Timeline model: a grant at cycle n puts the pulse at n+1; ack lands one cycle after
  // busy falls, or TO+2 cycles after the pulse if busy never completes.
  int            md_last = NM - 1;
  int            md_g;
  int            md_issue;
  int            md_ack;
  int            md_idle_from = 0;
  bit            md_inflight = 1'b0;
  bit            md_write;
  bit            md_err;
  bit            md_high;
  logic [AW-1:0] md_addr = '0;
  logic [DW-1:0] md_wdata = '0;
  logic [DW-1:0] md_rdata = '0;

  always @(negedge clk) begin : model
    logic [NM-1:0] e_busy;
    logic [NM-1:0] e_ack;
    logic [NM-1:0] e_err;
    logic [NM-1:0] reqs;
    logic          e_r;
    logic          e_w;
    int            n;
    n = cyc;
    if (reset) begin
      check_output("reset_ctrl", {m_busy, m_ack, m_err, memory_read_req, memory_write_req}, 0);
      check_output("reset_addr", memory_addr, 0);
      check_output("reset_wdata", memory_data_write, 0);
      check_output("reset_rdata", m_data_read, 0);
      md_last = NM - 1;
      md_inflight = 1'b0;
      md_idle_from = 0;
      md_addr = '0;
      md_wdata = '0;
      md_rdata = '0;
    end else begin
      e_r = md_inflight && (n == md_issue) && !md_write;
      e_w = md_inflight && (n == md_issue) && md_write;
      e_busy = (md_inflight && n >= md_issue && (md_ack < 0 || n < md_ack)) ? (ONE << md_g) : '0;
      e_ack = (md_inflight && n == md_ack) ? (ONE << md_g) : '0;
      e_err = (md_inflight && n == md_ack && md_err) ? (ONE << md_g) : '0;
      check_output("mem_read_req", memory_read_req, e_r);
      check_output("mem_write_req", memory_write_req, e_w);
      check_output("m_busy", m_busy, e_busy);
      check_output("m_ack", m_ack, e_ack);
      check_output("m_err", m_err, e_err);
      check_output("mem_addr", memory_addr, md_addr);
      check_output("mem_wdata", memory_data_write, md_wdata);
      check_output("m_data_read", m_data_read, md_rdata);

      reqs = m_read_req | m_write_req;
      if (md_inflight) begin
        if (n == md_ack) begin
          md_inflight = 1'b0;
          md_idle_from = n + 1;
        end else if (md_ack < 0 && n > md_issue) begin
          if (memory_busy) begin
            md_high = 1'b1;
          end else if (md_high) begin
            md_ack = n + 1;
            md_err = 1'b0;
            if (!md_write) md_rdata = memory_data_read;
          end
          if (md_ack < 0 && n >= md_issue + TO + 1) begin
            md_ack = n + 1;
            md_err = 1'b1;
          end
        end
      end else if (n >= md_idle_from && (|reqs) && !memory_busy) begin
        md_g = rr_pick(md_last, reqs);
        md_last = md_g;
        md_inflight = 1'b1;
        md_issue = n + 1;
        md_ack = -1;
        md_high = 1'b0;
        md_err = 1'b0;
        md_write = bit_of(m_write_req, md_g);
        md_addr = m_addr[md_g*AW +: AW];
        md_wdata = m_data_write[md_g*DW +: DW];
      end
    end
  end

  task automatic set_master(input int m, input bit rd, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_read_req  = rd ? (m_read_req | (ONE << m)) : (m_read_req & ~(ONE << m));
    m_write_req = wr ? (m_write_req | (ONE << m)) : (m_write_req & ~(ONE << m));
    m_addr[m*AW +: AW] = a;
    m_data_write[m*DW +: DW] = d;
  endtask

  task automatic wait_any_ack(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (|m_ack) got = 1'b1;
    end
    if (!got) check_output("ack_wait", 0, 1);
  endtask

  // One transaction from master m; request dropped the cycle after its ack.
  task automatic apply_stimulus(input int m, input bit rd, input bit wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    @(posedge clk); #1;
    set_master(m, rd, wr, a, d);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bit_of(m_ack, m)) got = 1'b1;
    end
    if (!got) check_output("ack_wait", 0, 1);
    @(posedge clk); #1;
    set_master(m, 1'b0, 1'b0, a, d);
  endtask

  function automatic int pc(input int i);
    return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1000;
  endfunction

  initial begin
    int base;
    int acks;
    int rel;
    int got;
    reset = 1'b1;
    m_read_req = '0;
    m_write_req = '0;
    m_addr = '0;
    m_data_write = '0;
    force_busy = 1'b0;
    dn_never = 1'b0;
    dn_len = 2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_m_ack", m_ack, 0);
    check_output("reset_mem_req", {memory_read_req, memory_write_req}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Round robin: all four masters read continuously for eight grants.
    base = pulse_count;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 1'b0, 26'h100 + 26'(i), 32'h0);
    got = 0;
    for (int k = 0; k < 400 && got < 8; k++) begin
      @(negedge clk);
      if (|m_ack) got++;
    end
    if (got < 8) check_output("rr_ack_wait", got, 8);
    @(posedge clk); #1 m_read_req = '0;
    for (int i = 0; i < 8; i++)
      check_output("rr_order", (base + i < pulse_master.size()) ? pulse_master[base+i] : -1, i % NM);

    // Single read, busy high three cycles.
    mem[26'h0000123] = 32'hDEADBEEF;
    dn_len = 3;
    base = pulse_count;
    apply_stimulus(0, 1'b1, 1'b0, 26'h0000123, 32'h0);
    check_output("read_pulses", pulse_count - base, 1);
    check_output("read_op_is_read", (base < pulse_write.size()) ? pulse_write[base] : 1'b1, 0);
    check_output("read_addr", (base < pulse_addr.size()) ? pulse_addr[base] : '1, 26'h0000123);
    check_output("read_ack_latency", last_ack_cyc - pc(base), 5);
    check_output("read_data", last_ack_data, 32'hDEADBEEF);
    check_output("read_err", last_ack_err, 0);

    // Minimum latency: busy for one cycle.
    dn_len = 1;
    base = pulse_count;
    apply_stimulus(2, 1'b1, 1'b0, 26'h55, 32'h0);
    check_output("min_latency", last_ack_cyc - pc(base), 3);

    // Write wins over read from the same master.
    dn_len = 2;
    base = pulse_count;
    apply_stimulus(1, 1'b1, 1'b1, 26'h3FFFFFF, 32'hA5A5A5A5);
    check_output("wr_pulses", pulse_count - base, 1);
    check_output("wr_op_is_write", (base < pulse_write.size()) ? pulse_write[base] : 1'b0, 1);
    check_output("wr_addr", (base < pulse_addr.size()) ? pulse_addr[base] : '0, 26'h3FFFFFF);
    check_output("wr_data", (base < pulse_data.size()) ? pulse_data[base] : '0, 32'hA5A5A5A5);
    apply_stimulus(3, 1'b1, 1'b0, 26'h3FFFFFF, 32'h0);
    check_output("wr_readback", last_ack_data, 32'hA5A5A5A5);

    // Timeout: downstream never goes busy.
    dn_never = 1'b1;
    base = pulse_count;
    apply_stimulus(0, 1'b1, 1'b0, 26'h777, 32'h0);
    check_output("to_err", last_ack_err, 1);
    check_output("to_latency", last_ack_cyc - pc(base), 18);
    check_output("to_data_kept", last_ack_data, 32'hA5A5A5A5);
    dn_never = 1'b0;
    dn_len = 3;
    apply_stimulus(0, 1'b1, 1'b0, 26'h0000123, 32'h0);
    check_output("after_to_err", last_ack_err, 0);
    check_output("after_to_data", last_ack_data, 32'hDEADBEEF);

    // Busy already high when master 0 requests.
    @(posedge clk); #1 force_busy = 1'b1;
    base = pulse_count;
    set_master(0, 1'b1, 1'b0, 26'h0000123, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check_output("busy_hold_pulses", pulse_count - base, 0);
    force_busy = 1'b0;
    rel = cyc;
    wait_any_ack(100);
    @(posedge clk); #1 set_master(0, 1'b0, 1'b0, 26'h0000123, 32'h0);
    check_output("busy_release_issue", pc(base) - rel, 1);
    check_output("busy_release_latency", last_ack_cyc - pc(base), 5);

    // Reset during WAIT_DONE of a master 2 read.
    dn_len = 10;
    base = pulse_count;
    @(posedge clk); #1 set_master(2, 1'b1, 1'b0, 26'h200, 32'h0);
    got = 0;
    for (int k = 0; k < 50 && got == 0; k++) begin
      @(negedge clk);
      if (memory_read_req) got = 1;
    end
    if (got == 0) check_output("mid_pulse_wait", 0, 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    acks = ack_count;
    @(negedge clk);
    check_output("mid_rst_busy", m_busy, 0);
    check_output("mid_rst_ack", m_ack, 0);
    check_output("mid_rst_req", {memory_read_req, memory_write_req}, 0);
    check_output("mid_rst_addr", memory_addr, 0);
    set_master(2, 1'b0, 1'b0, 26'h200, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = pulse_count;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 1'b0, 26'h300 + 26'(i), 32'h0);
    wait_any_ack(100);
    @(posedge clk); #1 m_read_req = '0;
    check_output("mid_rst_no_ack", ack_count - acks, 1);
    check_output("mid_rst_first_grant", (base < pulse_master.size()) ? pulse_master[base] : -1, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised round-robin arbiter that lets `NUM_MASTERS` requesters share the single HAL memory port (`memory_read_req` / `memory_write_req` / `memory_addr` / `memory_data_write` / `memory_data_read` / `memory_busy`). Today only the control unit drives that port. This block sits between the requesters (control unit, ADC capture, FrontPanel DMA) and `hal`. It adds per-master handshakes, fair arbitration, and a transaction timeout with error reporting.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 26: memory word address width.
- `DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 1023: abort limit while waiting on `memory_busy`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m_read_req` in `NUM_MASTERS`: per-master read request, level.
- `m_write_req` in `NUM_MASTERS`: per-master write request, level; wins over a read from the same master.
- `m_addr` in `NUM_MASTERS*ADDR_WIDTH`: flattened; master i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `m_data_write` in `NUM_MASTERS*DATA_WIDTH`: flattened write data, same packing as `m_addr`.
- `m_data_read` out `DATA_WIDTH`: shared read data; valid with `m_ack`, held until the next completion.
- `m_busy` out `NUM_MASTERS`: master i's transaction is in flight.
- `m_ack` out `NUM_MASTERS`: 1-cycle completion pulse.
- `m_err` out `NUM_MASTERS`: 1-cycle pulse, coincident with `m_ack`, when the transaction timed out.
- `memory_read_req`, `memory_write_req` out 1 each: downstream request, 1-cycle pulse.
- `memory_addr` out `ADDR_WIDTH`, `memory_data_write` out `DATA_WIDTH`: latched downstream address and data.
- `memory_data_read` in `DATA_WIDTH`: downstream read data.
- `memory_busy` in 1: downstream busy.

## Operation
- Master contract:
  - Hold the request and the `m_addr` / `m_data_write` values stable until `m_ack[i]`.
  - Deassert the request in the cycle after `m_ack[i]`, or keep it high to request again.
- Downstream contract:
  - A request is a 1-cycle pulse.
  - `memory_busy` rises after acceptance.
  - Completion is the first cycle `memory_busy` is low after having been high.
- State machine (IDLE, ISSUE, ACCEPT, WAIT_DONE, DONE):
  - IDLE: when any request is present and `memory_busy`=0, select a grant, latch op/address/data into the output registers, set `m_busy[g]`, go to ISSUE. Otherwise stay.
  - ISSUE: exactly one of `memory_read_req` / `memory_write_req` is high. Go to ACCEPT.
  - ACCEPT: wait for `memory_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `memory_busy`=0. On completion, capture `memory_data_read` into `m_data_read` (reads only) and go to DONE.
  - DONE: `m_ack[g]`=1, clear `m_busy[g]`, return to IDLE.
- Arbitration:
  - Round-robin. Search starts at `last_grant+1` modulo `NUM_MASTERS`; the first requester found wins.
  - `last_grant` updates on every grant.
  - Reset value of `last_grant` is `NUM_MASTERS-1`, so master 0 has first priority.
  - A master that is the sole requester may be granted back-to-back.
- Timeout:
  - A counter clears on entry to ACCEPT and counts during ACCEPT and WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), go to DONE with `m_err[g]`=1.
  - `m_data_read` is unchanged on a timeout.
- Simultaneous events:
  - Requests that arrive while a transaction is in flight wait; no queueing beyond the level request itself.
  - If the read and write requests are both high, the arbiter performs a write.
  - A request dropped before grant is simply not served.
- Reset mid-transaction:
  - All state clears immediately and the transaction is abandoned.
  - No `m_ack` is issued.
  - The downstream request drops asynchronously.
- Reset values: every output is 0; state is IDLE.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum latency:
  - Request sampled at edge t, memory request high in cycle t+1.
  - If `memory_busy` is high in t+2 and low in t+3, `m_ack` is high in t+4.
- The downstream request is asserted for exactly one cycle per transaction.
- Bus dead time: at least one cycle (DONE) between completion and the next ISSUE.
- `m_busy[i]` is high from the cycle after grant through the cycle before `m_ack[i]`.

## Test plan
- Single read: master 0 reads address 0x0000123; the downstream model returns 0xDEADBEEF after busy is high for 3 cycles.
  - Required: one `memory_read_req` pulse with `memory_addr`=0x0000123.
  - Required: `m_ack[0]` exactly 1 cycle after busy falls, with `m_data_read`=0xDEADBEEF.
- Round-robin fairness: `NUM_MASTERS`=4, all masters request continuously for 8 transactions.
  - Required grant order: 0,1,2,3,0,1,2,3, with no master starved.
- Write priority and data: master 1 asserts read and write together with data 0xA5A5A5A5 to address 0x3FFFFFF.
  - Required: `memory_write_req` only, `memory_addr`=0x3FFFFFF, `memory_data_write`=0xA5A5A5A5.
- Timeout: `TIMEOUT_CYCLES`=16 and `memory_busy` never rises.
  - Required: `m_ack[0]` and `m_err[0]` pulse together, 18 cycles after ISSUE.
  - Required: `m_data_read` is unchanged, and the next request is served normally.
- Reset mid-transaction: assert `reset` during WAIT_DONE.
  - Required: all outputs 0 within the same cycle, and no `m_ack`.
  - Required: after release, master 0 is granted first.
- Busy at request: `memory_busy` is already high when master 0 requests.
  - Required: no memory request is issued until busy falls; then normal latency.
